// File: rtl/bounded_updown_counter.sv
// Bounded up/down counter with programmable step, lower/upper bounds and
// wrap / saturate / one-shot-halt boundary handling.
//
// Ports:
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   enable        count enable
//   up_down       1: count up, 0: count down
//   load_en       synchronous load (ignores enable, bounds and halt)
//   load_val      value loaded on load_en
//   step          unsigned step magnitude; 0 means hold
//   lo_bound      lower count bound
//   hi_bound      upper count bound
//   mode          00 wrap, 01 saturate, 10 one-shot halt, 11 wrap
//   clr_flags     clears sat_sticky and halted (a boundary event wins)
//   count         registered count
//   tc_pulse      registered one-cycle pulse after a boundary event
//   sat_sticky    registered sticky boundary flag
//   halted        registered one-shot stopped flag
//   cfg_err       combinational, lo_bound > hi_bound
module bounded_updown_counter #(
  parameter int unsigned       WIDTH   = 8,
  parameter int unsigned       STEP_W  = 4,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              up_down,
  input  logic              load_en,
  input  logic [WIDTH-1:0]  load_val,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  lo_bound,
  input  logic [WIDTH-1:0]  hi_bound,
  input  logic [1:0]        mode,
  input  logic              clr_flags,
  output logic [WIDTH-1:0]  count,
  output logic              tc_pulse,
  output logic              sat_sticky,
  output logic              halted,
  output logic              cfg_err
);

  localparam int unsigned EW = WIDTH + 1;

  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  logic [EW-1:0]    cnt_x;
  logic [EW-1:0]    step_x;
  logic [EW-1:0]    lo_x;
  logic [EW-1:0]    hi_x;
  logic [EW-1:0]    sum_up;
  logic [EW-1:0]    diff_dn;
  logic [EW-1:0]    lo_plus_step;
  logic             up_evt;
  logic             dn_evt;
  logic             boundary_evt;
  logic             qualify;
  logic             clamp_mode;

  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;
  logic             sticky_nxt;
  logic             halted_nxt;

  // Configuration check is combinational so it gates the very next edge.
  assign cfg_err = (lo_bound > hi_bound);

  // Widened operands: one extra bit keeps overflow/underflow visible.
  assign cnt_x        = EW'(count);
  assign step_x       = EW'(step);
  assign lo_x         = EW'(lo_bound);
  assign hi_x         = EW'(hi_bound);
  assign sum_up       = cnt_x + step_x;
  assign diff_dn      = cnt_x - step_x;
  assign lo_plus_step = lo_x + step_x;

  assign up_evt       = (sum_up > hi_x);
  assign dn_evt       = (cnt_x < lo_plus_step);
  assign boundary_evt = up_down ? up_evt : dn_evt;

  assign qualify    = enable && !load_en && !cfg_err && !halted && (step != '0);
  assign clamp_mode = (mode == MODE_SAT) || (mode == MODE_ONESHOT);

  // Next-state for count and flags; load beats clear/count.
  always_comb begin
    count_nxt  = count;
    tc_nxt     = 1'b0;
    sticky_nxt = sat_sticky;
    halted_nxt = halted;

    if (load_en) begin
      count_nxt  = load_val;
      halted_nxt = 1'b0;
    end else begin
      if (clr_flags) begin
        sticky_nxt = 1'b0;
        halted_nxt = 1'b0;
      end
      if (qualify) begin
        if (boundary_evt) begin
          tc_nxt     = 1'b1;
          sticky_nxt = 1'b1;
          if (clamp_mode) begin
            count_nxt = up_down ? hi_bound : lo_bound;
          end else begin
            count_nxt = up_down ? lo_bound : hi_bound;
          end
          if (mode == MODE_ONESHOT) begin
            halted_nxt = 1'b1;
          end
        end else begin
          count_nxt = up_down ? sum_up[WIDTH-1:0] : diff_dn[WIDTH-1:0];
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= RST_VAL;
      tc_pulse   <= 1'b0;
      sat_sticky <= 1'b0;
      halted     <= 1'b0;
    end else begin
      count      <= count_nxt;
      tc_pulse   <= tc_nxt;
      sat_sticky <= sticky_nxt;
      halted     <= halted_nxt;
    end
  end

endmodule
